// File: rtl/lab2_stim_ctrl.sv
// lab2_stim_ctrl: drives a 2-input gate circuit through the vectors 00, 01, 10 and 11.
// After each vector it waits for the circuit to settle, then samples the synchronized out1.
// It counts samples that disagree with EXPECT, and out1 transitions seen while settling.
module lab2_stim_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [3:0]  EXPECT        = 4'b1111
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       out1,
  output logic       in1,
  output logic       in2,
  output logic       busy,
  output logic       done,
  output logic [3:0] result,
  output logic [2:0] err_cnt,
  output logic [3:0] glitch_cnt
);

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    SAMPLE,
    DONE
  } state_e;

  state_e     state_q, state_d;
  logic       s1_q, s2_q, s3_q;
  logic [1:0] vec_q, vec_d;
  logic [1:0] stim_q, stim_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] result_q, result_d;
  logic [2:0] err_q, err_d;
  logic [3:0] glitch_q, glitch_d;

  // out1 is asynchronous. Two flops resolve metastability, and a third holds the previous synchronized value for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= out1;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: each vector takes one apply cycle, SETTLE_CYCLES settle cycles and one sample cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = APPLY;
      APPLY:   state_d = SETTLE;
      SETTLE:  if (cnt_q <= 8'd1) state_d = SAMPLE;
      SAMPLE:  state_d = (vec_q == 2'd3) ? DONE : APPLY;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs decoded purely from the current state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    if (state_q != IDLE) busy = 1'b1;
    if (state_q == DONE) done = 1'b1;
  end

  // Datapath next values. Results and counters are cleared only when a run is accepted, so they hold after DONE.
  always_comb begin
    vec_d    = vec_q;
    stim_d   = stim_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    err_d    = err_q;
    glitch_d = glitch_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          vec_d    = 2'd0;
          result_d = 4'd0;
          err_d    = 3'd0;
          glitch_d = 4'd0;
        end
      end
      APPLY: begin
        stim_d = vec_q;
        cnt_d  = SETTLE_LOAD;
      end
      SETTLE: begin
        cnt_d = cnt_q - 8'd1;
        if ((s2_q != s3_q) && (glitch_q != 4'hF)) glitch_d = glitch_q + 4'd1;
      end
      SAMPLE: begin
        result_d[vec_q] = s2_q;
        if (s2_q != EXPECT[vec_q]) err_d = err_q + 3'd1;
        if (vec_q != 2'd3) vec_d = vec_q + 2'd1;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_q    <= 2'd0;
      stim_q   <= 2'd0;
      cnt_q    <= 8'd0;
      result_q <= 4'd0;
      err_q    <= 3'd0;
      glitch_q <= 4'd0;
    end else begin
      vec_q    <= vec_d;
      stim_q   <= stim_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      err_q    <= err_d;
      glitch_q <= glitch_d;
    end
  end

  assign in1        = stim_q[1];
  assign in2        = stim_q[0];
  assign result     = result_q;
  assign err_cnt    = err_q;
  assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_lab2_stim_ctrl.sv
// Testbench for lab2_stim_ctrl.
// The circuit under test is modelled as a truth table indexed by {in1,in2}.
// A flip bit is XORed onto that table output to inject glitches.
module tb_lab2_stim_ctrl;

  localparam logic [3:0] EXPECT_BITS = 4'b1111;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       out1;
  logic       in1;
  logic       in2;
  logic       busy;
  logic       done;
  logic [3:0] result;
  logic [2:0] err_cnt;
  logic [3:0] glitch_cnt;

  logic [3:0] truthTable;
  logic       flip;
  int         compared   = 0;
  int         mismatched = 0;
  int         lastVec;

  lab2_stim_ctrl #(
    .SETTLE_CYCLES(4),
    .EXPECT       (EXPECT_BITS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .out1      (out1),
    .in1       (in1),
    .in2       (in2),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .err_cnt   (err_cnt),
    .glitch_cnt(glitch_cnt)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Combinational gate circuit under test, with optional glitch injection
  assign out1 = truthTable[{in1, in2}] ^ flip;

  // Global guard so the run can never hang
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Reference: the number of vectors whose sampled value differs from EXPECT
  function automatic int modelErr(input logic [3:0] tbl);
    return $countones(tbl ^ EXPECT_BITS);
  endfunction

  // Reference: each change of the circuit output between consecutively applied vectors counts once.
  // The first vector is compared against the vector held before the run began.
  function automatic int modelGlitch(input logic [3:0] tbl, input int prev);
    int g = 0;
    int p = prev;
    for (int v = 0; v < 4; v++) begin
      if (tbl[v] != tbl[p]) g++;
      p = v;
    end
    return (g > 15) ? 15 : g;
  endfunction

  // One run. glitchMode: 0 = none, 1 = low pulse inside the vector-2 settle window, 2 = toggle out1 every cycle.
  task automatic applyStimulus(input logic [3:0] tbl, input bit pokeBusy, input int glitchMode, input bit doReset);
    int doneCycle;
    int doneHigh;
    int busyHigh;
    int expGlitch;
    bit resetHit;
    truthTable = tbl;
    flip       = 1'b0;
    repeat (5) @(negedge clk);
    expGlitch = modelGlitch(tbl, lastVec);
    if (glitchMode == 1) expGlitch = expGlitch + 2;
    if (glitchMode == 2) expGlitch = 15;
    doneCycle = -1;
    doneHigh  = 0;
    busyHigh  = 0;
    resetHit  = 1'b0;
    @(negedge clk);
    start = 1'b1;
    if (glitchMode == 2) flip = ~flip;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
      if (busy) busyHigh++;
      if (done) begin
        doneHigh++;
        if (doneCycle < 0) doneCycle = cyc;
      end
      if ((cyc == 2) || (cyc == 8) || (cyc == 14) || (cyc == 20))
        checkOutput("vectorOrder", 32'({in1, in2}), 32'((cyc - 2) / 6));
      if (pokeBusy && (cyc == 9)) start = 1'b1;
      if (pokeBusy && (cyc == 10)) start = 1'b0;
      if (glitchMode == 2 && cyc <= 24) flip = ~flip;
      if (glitchMode == 1 && cyc == 14) flip = 1'b1;
      if (glitchMode == 1 && cyc == 15) flip = 1'b0;
      if (doReset && (cyc == 15)) begin
        rst = 1'b1;
        #1;
        checkOutput("resetMidRun", 32'({in1, in2, busy, done, result, err_cnt, glitch_cnt}), 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        lastVec  = 0;
        resetHit = 1'b1;
        break;
      end
    end
    if (!resetHit) begin
      checkOutput("doneCycle", 32'(doneCycle), 32'd25);
      checkOutput("donePulseWidth", 32'(doneHigh), 32'd1);
      checkOutput("busyCycles", 32'(busyHigh), 32'd25);
      checkOutput("vectorHeld", 32'({in1, in2}), 32'd3);
      checkOutput("glitchCnt", 32'(glitch_cnt), 32'(expGlitch));
      if (glitchMode != 2) begin
        checkOutput("result", 32'(result), 32'(tbl));
        checkOutput("errCnt", 32'(err_cnt), 32'(modelErr(tbl)));
      end
      lastVec = 3;
    end
  endtask

  // Directed sequence followed by randomized runs
  initial begin
    int  n;
    bit  seen;
    rst        = 1'b1;
    start      = 1'b0;
    flip       = 1'b0;
    truthTable = 4'b1111;
    lastVec    = 0;
    repeat (2) @(negedge clk);
    checkOutput("resetState", 32'({in1, in2, busy, done, result, err_cnt, glitch_cnt}), 32'd0);
    rst = 1'b0;

    $display("[TB] nominal run");
    applyStimulus(4'b1111, 1'b0, 0, 1'b0);
    $display("[TB] out1 follows in1");
    applyStimulus(4'b1100, 1'b0, 0, 1'b0);
    $display("[TB] single glitch pulse on vector 2");
    applyStimulus(4'b1111, 1'b0, 1, 1'b0);
    $display("[TB] toggle storm saturates glitch count");
    applyStimulus(4'b1111, 1'b0, 2, 1'b0);
    $display("[TB] start pulsed while busy");
    applyStimulus(4'b1111, 1'b1, 0, 1'b0);
    $display("[TB] reset during vector 2 settle, then fresh run");
    applyStimulus(4'b1111, 1'b0, 0, 1'b1);
    applyStimulus(4'b1111, 1'b0, 0, 1'b0);

    $display("[TB] start held high across DONE");
    truthTable = 4'b1111;
    flip       = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    checkOutput("holdFirstDone", 32'(seen), 32'd1);
    @(negedge clk);
    checkOutput("holdIdleGap", 32'(busy), 32'd0);
    @(negedge clk);
    checkOutput("holdRestart", 32'(busy), 32'd1);
    start = 1'b0;
    n     = 1;
    seen  = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      n++;
      if (done) seen = 1'b1;
    end
    checkOutput("holdSecondDone", 32'(n), 32'd25);
    lastVec = 3;

    $display("[TB] randomized runs");
    for (int r = 0; r < 8; r++) begin
      applyStimulus(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 0,
                    ($urandom_range(0, 5) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/lab2_stim_ctrl.md
LAB2_STIM_CTRL -- requirements
Module: lab2_stim_ctrl

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 4: cycles waited after applying each vector before sampling; legal range 1..255.
REQ-002 The block SHALL have parameter EXPECT, default 4'b1111: expected out1 per vector, indexed by {in1,in2}.
REQ-003 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port start  input  1  request to run one full test sequence; sampled only in IDLE.
REQ-006 Port out1  input  1  output of the gate-level circuit under test; asynchronous to clk.
REQ-007 Port in1  output  1  registered stimulus bit to the circuit under test (vector index bit 1).
REQ-008 Port in2  output  1  registered stimulus bit to the circuit under test (vector index bit 0).
REQ-009 Port busy  output  1  high in every state except IDLE.
REQ-010 Port done  output  1  one-cycle pulse at sequence completion.
REQ-011 Port result  output  4  captured out1 per vector; bit n corresponds to vector n.
REQ-012 Port err_cnt  output  3  count of vectors where the captured out1 differs from EXPECT.
REQ-013 Port glitch_cnt  output  4  count of out1 transitions observed during settle windows; saturates at 15.

Function
REQ-014 out1 SHALL pass through a 2-flop synchronizer (s1, s2) plus a history flop s3; all sampling and glitch detection SHALL use s2 and s3 only.
REQ-015 The FSM SHALL have the states IDLE, APPLY, SETTLE, SAMPLE and DONE, held in a registered state variable.
REQ-016 IDLE transition: start=1 -> APPLY; vec=0; result, err_cnt and glitch_cnt cleared on the same edge.
REQ-017 APPLY SHALL last 1 cycle: {in1,in2} <= vec; settle counter <= SETTLE_CYCLES; next state SETTLE.
REQ-018 SETTLE SHALL decrement the counter each cycle, stay for exactly SETTLE_CYCLES cycles, then go to SAMPLE.
REQ-019 In SETTLE, each cycle with s2 != s3 SHALL increment glitch_cnt, which SHALL hold at 15.
REQ-020 SAMPLE SHALL last 1 cycle: result[vec] <= s2; if s2 != EXPECT[vec], err_cnt increments.
REQ-021 SAMPLE exit: if vec==3, go to DONE; otherwise vec <= vec+1 and go to APPLY.
REQ-022 The vector order SHALL be fixed: 00, 01, 10, 11, with no wrap or repeat within one run.
REQ-023 DONE SHALL last 1 cycle: done=1; next state IDLE.
REQ-024 result, err_cnt and glitch_cnt SHALL hold their values after DONE until the next accepted start or reset.
REQ-025 in1 and in2 SHALL hold the last vector (11) after DONE until the next run or reset.
REQ-026 start while busy=1 SHALL be ignored with no side effect.
REQ-027 start held high across DONE SHALL begin a new run from the IDLE cycle that follows DONE.
REQ-028 Latency: with start accepted at edge k, done SHALL be high during the cycle after edge k + 4*(SETTLE_CYCLES+2) + 1, which is cycle 25 for the default settle of 4.
REQ-029 err_cnt SHALL never exceed 4, and 3 bits SHALL suffice with no saturation logic required.

Reset
REQ-030 rst=1 SHALL, asynchronously and in any state (including mid-SETTLE), force state=IDLE, vec=0, in1=0, in2=0, busy=0, done=0, result=0, err_cnt=0, glitch_cnt=0, and all synchronizer and counter flops to 0.
REQ-031 After rst deasserts, the block SHALL remain in IDLE until start is sampled high; a subsequent run SHALL begin at vector 00.

Verification
REQ-032 Reset: assert rst mid-clock -> all outputs 0 immediately, without waiting for a clock edge.
REQ-033 Nominal: defaults, out1 tied 1, single start pulse -> {in1,in2} steps 00,01,10,11; done in cycle 25; result=4'b1111, err_cnt=0, glitch_cnt=0.
REQ-034 Mismatch: out1 driven equal to in1 -> result=4'b1100, err_cnt=2.
REQ-035 Glitch: out1 toggled 1->0->1 inside the settle window of vector 2 -> glitch_cnt=2, result[2]=1; 20 toggles across a run -> glitch_cnt=15.
REQ-036 Busy start: start pulsed during SETTLE of vector 1 -> sequence, timing and done cycle identical to the nominal case.
REQ-037 Reset mid-run: rst asserted during SETTLE of vector 2, then start -> outputs cleared; new run starts at 00 and completes in 25 cycles.
